// File: rtl/tanh_pkg.sv
// Shared constants and types for the tanh activation (S1.5.6 sign-magnitude).
package tanh_pkg;

  localparam int ONE       = 64;
  localparam int LIN_MAX   = 16;
  localparam int SAT_MIN   = 192;
  localparam int LUT_DEPTH = 177;
  localparam int LUT_W     = 7;
  localparam int LUT_IDX_W = 8;

  typedef struct packed {
    logic        sign;
    logic [10:0] mag;
  } sm_word_t;

  typedef enum logic [1:0] {
    REG_LIN = 2'd0,
    REG_ROM = 2'd1,
    REG_SAT = 2'd2
  } region_t;

endpackage

// File: rtl/tanh_lut.sv
// Combinational ROM: floor(tanh(m/64)*64) for m in [16,192], indexed by m-16.
module tanh_lut
  import tanh_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [LUT_W-1:0]     val_o
);

  // Each range is the run of magnitudes sharing one floored tanh value.
  always_comb begin
    val_o = 7'd0;
    case (idx_i) inside
      8'd0:             val_o = 7'd15;
      8'd1:             val_o = 7'd16;
      8'd2:             val_o = 7'd17;
      8'd3:             val_o = 7'd18;
      8'd4:             val_o = 7'd19;
      8'd5:             val_o = 7'd20;
      8'd6:             val_o = 7'd21;
      [8'd7:8'd8]:      val_o = 7'd22;
      8'd9:             val_o = 7'd23;
      8'd10:            val_o = 7'd24;
      8'd11:            val_o = 7'd25;
      8'd12:            val_o = 7'd26;
      [8'd13:8'd14]:    val_o = 7'd27;
      8'd15:            val_o = 7'd28;
      8'd16:            val_o = 7'd29;
      8'd17:            val_o = 7'd30;
      [8'd18:8'd19]:    val_o = 7'd31;
      8'd20:            val_o = 7'd32;
      8'd21:            val_o = 7'd33;
      [8'd22:8'd23]:    val_o = 7'd34;
      8'd24:            val_o = 7'd35;
      [8'd25:8'd26]:    val_o = 7'd36;
      8'd27:            val_o = 7'd37;
      [8'd28:8'd29]:    val_o = 7'd38;
      8'd30:            val_o = 7'd39;
      [8'd31:8'd32]:    val_o = 7'd40;
      [8'd33:8'd34]:    val_o = 7'd41;
      [8'd35:8'd36]:    val_o = 7'd42;
      8'd37:            val_o = 7'd43;
      [8'd38:8'd39]:    val_o = 7'd44;
      [8'd40:8'd41]:    val_o = 7'd45;
      [8'd42:8'd44]:    val_o = 7'd46;
      [8'd45:8'd46]:    val_o = 7'd47;
      [8'd47:8'd48]:    val_o = 7'd48;
      [8'd49:8'd51]:    val_o = 7'd49;
      [8'd52:8'd53]:    val_o = 7'd50;
      [8'd54:8'd56]:    val_o = 7'd51;
      [8'd57:8'd59]:    val_o = 7'd52;
      [8'd60:8'd62]:    val_o = 7'd53;
      [8'd63:8'd66]:    val_o = 7'd54;
      [8'd67:8'd70]:    val_o = 7'd55;
      [8'd71:8'd75]:    val_o = 7'd56;
      [8'd76:8'd80]:    val_o = 7'd57;
      [8'd81:8'd86]:    val_o = 7'd58;
      [8'd87:8'd93]:    val_o = 7'd59;
      [8'd94:8'd103]:   val_o = 7'd60;
      [8'd104:8'd116]:  val_o = 7'd61;
      [8'd117:8'd139]:  val_o = 7'd62;
      [8'd140:8'd176]:  val_o = 7'd63;
      default:          val_o = 7'd0;
    endcase
  end

endmodule

// File: rtl/tanh_calc.sv
// Registered tanh(x) on a sign-magnitude operand: linear / ROM / saturation regions.
// Optional out_sat flag port when TANH_SAT_FLAG_EN is defined.
module tanh_calc
  import tanh_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int FRAC_BITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out
`ifdef TANH_SAT_FLAG_EN
  ,
  output logic             out_sat
`endif
);

  localparam int MAG_W = WIDTH - 1;

  // ROM contents only hold for six fractional bits.
  if (FRAC_BITS != 6) begin : g_bad_frac
    $error("tanh_calc: FRAC_BITS must be 6");
  end

  logic                 sign_s;
  logic [MAG_W-1:0]     mag_s;
  logic [LUT_IDX_W-1:0] lut_idx_s;
  logic [LUT_W-1:0]     lut_val_s;
  logic [LUT_W-1:0]     res_s;
  region_t              region_s;
  logic [WIDTH-1:0]     out_d;
  logic [WIDTH-1:0]     out_q;
  logic                 out_valid_q;

  assign sign_s    = in[WIDTH-1];
  assign mag_s     = in[MAG_W-1:0];
  assign lut_idx_s = LUT_IDX_W'(mag_s - MAG_W'(LIN_MAX));

  tanh_lut u_lut (
    .idx_i (lut_idx_s),
    .val_o (lut_val_s)
  );

  always_comb begin
    region_s = REG_LIN;
    if (mag_s < MAG_W'(LIN_MAX)) begin
      region_s = REG_LIN;
    end else if (mag_s <= MAG_W'(SAT_MIN)) begin
      region_s = REG_ROM;
    end else begin
      region_s = REG_SAT;
    end
  end

  always_comb begin
    res_s = '0;
    case (region_s)
      REG_LIN: res_s = mag_s[LUT_W-1:0];
      REG_ROM: res_s = lut_val_s;
      REG_SAT: res_s = LUT_W'(ONE);
      default: res_s = '0;
    endcase
  end

  // A zero result is forced positive so -0 never leaves the block.
  always_comb begin
    out_d = {sign_s & (res_s != '0), {(MAG_W - LUT_W){1'b0}}, res_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q <= out_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef TANH_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (in_valid) begin
      sat_q <= (region_s == REG_SAT);
    end
  end

  assign out_sat = sat_q;
`endif

endmodule

// File: tb/tb_tanh_calc.sv
// Directed-vector bench for tanh_calc plus a full 4096-input sweep against a real-valued model.
module tb_tanh_calc;
  import tanh_pkg::*;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_s;
  logic        out_valid;
  logic [11:0] out_s;
`ifdef TANH_SAT_FLAG_EN
  logic        out_sat;
`endif

  int n_vec;
  int n_bad;

  tanh_calc #(.WIDTH(12), .FRAC_BITS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in_s),
    .out_valid (out_valid),
    .out       (out_s)
`ifdef TANH_SAT_FLAG_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] x);
    @(negedge clk);
    in_valid = v;
    in_s     = x;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] golden(input logic [11:0] x);
    int   m;
    int   r;
    m = int'(x[10:0]);
    if (m < 16) r = m;
    else if (m <= 192) r = int'($floor($tanh(real'(m) / 64.0) * 64.0));
    else r = 64;
    if (r == 0) return 12'h000;
    return {x[11], 4'b0000, 7'(r)};
  endfunction

  vec_t vecs[$];

  initial begin
    sm_word_t w;
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_s     = 12'h040;

    vecs = '{
      '{12'h008, 12'h008}, '{12'h00F, 12'h00F}, '{12'h808, 12'h808}, '{12'h80F, 12'h80F},
      '{12'h009, 12'h009}, '{12'h800, 12'h000}, '{12'h000, 12'h000},
      '{12'h010, 12'h00F}, '{12'h040, 12'h030}, '{12'h0C0, 12'h03F},
      '{12'h810, 12'h80F}, '{12'h840, 12'h830}, '{12'h8C0, 12'h83F},
      '{12'h020, 12'h01D}, '{12'h080, 12'h03D}, '{12'h060, 12'h039},
      '{12'h0C1, 12'h040}, '{12'h100, 12'h040}, '{12'h3FF, 12'h040}, '{12'h7FF, 12'h040},
      '{12'h8C1, 12'h840}, '{12'h900, 12'h840}, '{12'hFFF, 12'h840}
    };

    // Reset held with a valid operand present
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out_s, 12'h000);
    check("reset_valid", {11'd0, out_valid}, 12'h000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_out", out_s, 12'h030);
    check("release_valid", {11'd0, out_valid}, 12'h001);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].x);
      check($sformatf("vec%0d_%03h", i, vecs[i].x), out_s, vecs[i].y);
      check($sformatf("vec%0d_valid", i), {11'd0, out_valid}, 12'h001);
    end

    // Back-to-back stream, then hold with in_valid low
    drive(1'b1, 12'h010);
    check("stream0", out_s, 12'h00F);
    drive(1'b1, 12'h0C1);
    check("stream1", out_s, 12'h040);
    drive(1'b1, 12'h8C0);
    check("stream2", out_s, 12'h83F);
    drive(1'b0, 12'h123);
    check("hold0", out_s, 12'h83F);
    check("hold0_valid", {11'd0, out_valid}, 12'h000);
    drive(1'b0, 12'h7FF);
    check("hold1", out_s, 12'h83F);
    check("hold1_valid", {11'd0, out_valid}, 12'h000);

    // Reset asserted mid-stream drops the in-flight result
    drive(1'b1, 12'h040);
    check("pre_rst", out_s, 12'h030);
    @(negedge clk);
    in_s  = 12'h0C1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out_s, 12'h000);
    check("async_rst_valid", {11'd0, out_valid}, 12'h000);
    @(posedge clk);
    #1;
    check("rst_held_out", out_s, 12'h000);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out", out_s, 12'h000);
    check("post_rst_valid", {11'd0, out_valid}, 12'h000);

    // Exhaustive sweep against the floor(tanh) model
    for (int i = 0; i < 4096; i++) begin
      w = sm_word_t'(12'(i));
      drive(1'b1, w);
      check($sformatf("sweep_%03h", i), out_s, golden(12'(i)));
`ifdef TANH_SAT_FLAG_EN
      check($sformatf("sat_%03h", i), {11'd0, out_sat}, {11'd0, (w.mag > 11'd192)});
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
